// File: rtl/epc_stack_unit.sv
// Exception-PC stack for CP0: a DEPTH-entry LIFO of return addresses for nested exceptions.
// Hardware entry pushes, ERET pops, MTC0 overwrites the top; sticky overflow/underflow status.
module epc_stack_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_p,
  input  logic              r_h,
  input  logic              we_s,
  input  logic              we_h,
  input  logic              eret,
  input  logic              clr_err,
  input  logic              bd_p,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] pc_p,
  output logic [DATA_W-1:0] read_data,
  output logic [CNT_W-1:0]  depth,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf
);

  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [DATA_W-1:0] entry_d [DEPTH];
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [DATA_W-1:0] epc_t;
  logic              is_full, is_empty;

  assign is_full  = (depth_q == CNT_W'(DEPTH));
  assign is_empty = (depth_q == '0);

  // Delay-slot exceptions return to the branch, one instruction earlier (wraps mod 2^DATA_W).
  assign epc_t = bd_p ? (pc_p - DATA_W'(INSTR_BYTES)) : pc_p;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    depth_d = depth_q;
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    udf_d   = clr_err ? 1'b0 : udf_q;

    if (we_h && eret) begin
      entry_d[0] = epc_t;
      if (is_empty) begin
        depth_d = CNT_W'(1);
      end
    end else if (we_h) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        entry_d[i] = entry_q[i-1];
      end
      entry_d[0] = epc_t;
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + CNT_W'(1);
      end
    end else if (eret) begin
      if (is_empty) begin
        udf_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          entry_d[i] = entry_q[i+1];
        end
        // Vacated slots are zeroed so an empty stack reads back 0.
        entry_d[DEPTH-1] = '0;
        depth_d          = depth_q - CNT_W'(1);
      end
    end else if (we_s) begin
      entry_d[0] = write_data;
      if (is_empty) begin
        depth_d = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign read_data = (r_p || r_h) ? entry_q[0] : '0;
  assign depth     = depth_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_epc_stack_unit.sv
// Directed self-checking bench for epc_stack_unit with DEPTH=4, DATA_W=32.
module tb_epc_stack_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              r_p = 1'b0, r_h = 1'b0, we_s = 1'b0, we_h = 1'b0;
  logic              eret = 1'b0, clr_err = 1'b0, bd_p = 1'b0;
  logic [DATA_W-1:0] write_data = '0, pc_p = '0;
  logic [DATA_W-1:0] read_data;
  logic [CNT_W-1:0]  depth;
  logic              full, empty, ovf, udf;

  int checks = 0;
  int errors = 0;

  epc_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst(rst), .r_p(r_p), .r_h(r_h), .we_s(we_s), .we_h(we_h), .eret(eret),
    .clr_err(clr_err), .bd_p(bd_p), .write_data(write_data), .pc_p(pc_p),
    .read_data(read_data), .depth(depth), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge and are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_h = 1'b0; we_s = 1'b0; eret = 1'b0; clr_err = 1'b0; bd_p = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] pc, input logic bd);
    we_h = 1'b1; pc_p = pc; bd_p = bd;
    tick();
    idle();
  endtask

  task automatic pop();
    eret = 1'b1;
    tick();
    idle();
  endtask

  task automatic chk_state(input string name, input logic [DATA_W-1:0] exp_rd,
                           input int exp_depth, input logic exp_full, input logic exp_empty,
                           input logic exp_ovf, input logic exp_udf);
    checks++;
    if (read_data !== exp_rd || depth !== CNT_W'(exp_depth) || full !== exp_full ||
        empty !== exp_empty || ovf !== exp_ovf || udf !== exp_udf) begin
      errors++;
      $display("FAIL %s: got rd=%h depth=%0d full=%b empty=%b ovf=%b udf=%b, want rd=%h depth=%0d full=%b empty=%b ovf=%b udf=%b",
               name, read_data, depth, full, empty, ovf, udf,
               exp_rd, exp_depth, exp_full, exp_empty, exp_ovf, exp_udf);
    end
  endtask

  task automatic hard_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    r_p = 1'b1;
    #1 rst = 1'b0;
    #2 chk_state("reset_state", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    tick();
    chk_state("after_reset_idle", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bd_push();
    push(32'h0040_0010, 1'b1);
    chk_state("push_bd", 32'h0040_000C, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'h8000_0180, 1'b0);
    chk_state("push_nobd", 32'h8000_0180, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'h0000_0000, 1'b1);
    chk_state("push_bd_wrap", 32'hFFFF_FFFC, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    // Assert reset between edges while a push is being requested.
    we_h = 1'b1; pc_p = 32'h1234_5678;
    #2 rst = 1'b0;
    #1 chk_state("async_reset_midpush", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    we_h = 1'b0;
    #1 rst = 1'b1;
    tick();
    chk_state("after_async_reset", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] exp_top [4] = '{32'h500, 32'h400, 32'h300, 32'h200};
    for (int i = 1; i <= 4; i++) push(DATA_W'(i * 32'h100), 1'b0);
    chk_state("fill_4", 32'h400, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    push(32'h500, 1'b0);
    chk_state("push_full_ovf", 32'h500, 4, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (read_data !== exp_top[i]) begin
        errors++;
        $display("FAIL pop_order[%0d]: got %h want %h", i, read_data, exp_top[i]);
      end
      pop();
    end
    chk_state("drained", 32'h0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    clr_err = 1'b1;
    tick();
    idle();
    chk_state("clr_ovf", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_underflow();
    pop();
    chk_state("pop_empty_udf", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    clr_err = 1'b1;
    tick();
    idle();
    chk_state("clr_udf", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    clr_err = 1'b1; eret = 1'b1;
    tick();
    idle();
    chk_state("clr_vs_udf_set_wins", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    clr_err = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_sw_write();
    we_s = 1'b1; write_data = 32'hDEAD_BEEF; we_h = 1'b1; pc_p = 32'h1000; bd_p = 1'b0;
    tick();
    idle();
    chk_state("hw_beats_sw", 32'h1000, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    we_s = 1'b1;
    tick();
    idle();
    chk_state("sw_overwrite_top", 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    eret = 1'b1; we_s = 1'b1; write_data = 32'h5555_5555;
    tick();
    idle();
    chk_state("pop_beats_sw", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    we_s = 1'b1; write_data = 32'h0000_1234;
    tick();
    idle();
    chk_state("sw_on_empty", 32'h1234, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    hard_reset();
  endtask

  task automatic test_replace();
    push(32'h100, 1'b0);
    push(32'h200, 1'b0);
    we_h = 1'b1; eret = 1'b1; pc_p = 32'h300;
    tick();
    idle();
    chk_state("replace_top", 32'h300, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    r_p = 1'b0;
    #1 checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL read_gated: got %h want %h", read_data, 32'h0);
    end
    r_h = 1'b1;
    #1 checks++;
    if (read_data !== 32'h300) begin
      errors++;
      $display("FAIL read_hw_port: got %h want %h", read_data, 32'h300);
    end
    r_h = 1'b0; r_p = 1'b1;
    pop();
    chk_state("replace_kept_entry1", 32'h100, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    pop();
    we_h = 1'b1; eret = 1'b1; pc_p = 32'h400;
    tick();
    idle();
    chk_state("replace_on_empty", 32'h400, 1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_bd_push();
    test_overflow();
    test_underflow();
    test_sw_write();
    test_replace();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
